// File: rtl/dct_gram_pingpong.sv
// Ping-pong controller for the two 64-word intermediate G RAMs of the 2-D DCT.
// The row pass fills one bank while the column pass drains the other in transposed order.
module dct_gram_pingpong #(
   parameter int TRANSPOSE = 1,
   parameter int DW        = 24
) (
   input  logic          clk_in,
   input  logic          rst,
   input  logic          wr_req,
   input  logic [DW-1:0] wr_data,
   output logic          wr_rdy,
   input  logic          rd_req,
   output logic          rd_rdy,
   output logic [DW-1:0] rd_data,
   output logic          rd_valid,
   output logic          blk_done,
   output logic          wr_err,
   output logic          ram0_cs,
   output logic          ram1_cs,
   output logic          ram0_rnw,
   output logic          ram1_rnw,
   output logic [5:0]    ram0_add,
   output logic [5:0]    ram1_add,
   output logic [DW-1:0] ram_wr_data,
   input  logic [DW-1:0] ram0_rd_data,
   input  logic [DW-1:0] ram1_rd_data
);

   typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

   bank_st_e   st_q [2];
   bank_st_e   st_d [2];
   logic       wbank_q, wbank_d;
   logic       rbank_q, rbank_d;
   logic       rsel_q, rsel_d;
   logic       rd_valid_q, rd_valid_d;
   logic [5:0] wcnt_q, wcnt_d;
   logic [5:0] rcnt_q, rcnt_d;
   logic [5:0] raddr;
   logic       wr_acc, rd_acc, wr_last, rd_last;

   // Readiness depends only on registered state, so no req-to-rdy paths exist.
   assign wr_rdy  = (st_q[wbank_q] == EMPTY) || (st_q[wbank_q] == FILLING);
   assign rd_rdy  = (st_q[rbank_q] == FULL)  || (st_q[rbank_q] == DRAINING);
   assign wr_acc  = wr_req & wr_rdy;
   assign rd_acc  = rd_req & rd_rdy;
   assign wr_last = wr_acc && (wcnt_q == 6'd63);
   assign rd_last = rd_acc && (rcnt_q == 6'd63);
   assign raddr   = (TRANSPOSE != 0) ? {rcnt_q[2:0], rcnt_q[5:3]} : rcnt_q;

   assign blk_done    = rd_last;
   assign wr_err      = wr_req & ~wr_rdy;
   assign ram_wr_data = wr_data;
   assign rd_valid    = rd_valid_q;
   assign rd_data     = rsel_q ? ram1_rd_data : ram0_rd_data;

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         st_q[0]    <= EMPTY;
         st_q[1]    <= EMPTY;
         wbank_q    <= 1'b0;
         rbank_q    <= 1'b0;
         rsel_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         wcnt_q     <= 6'd0;
         rcnt_q     <= 6'd0;
      end else begin
         st_q[0]    <= st_d[0];
         st_q[1]    <= st_d[1];
         wbank_q    <= wbank_d;
         rbank_q    <= rbank_d;
         rsel_q     <= rsel_d;
         rd_valid_q <= rd_valid_d;
         wcnt_q     <= wcnt_d;
         rcnt_q     <= rcnt_d;
      end
   end

   // Writer and reader always own different banks, so both updates can apply at once.
   always_comb begin
      st_d[0]    = st_q[0];
      st_d[1]    = st_q[1];
      wbank_d    = wbank_q;
      rbank_d    = rbank_q;
      rsel_d     = rsel_q;
      wcnt_d     = wcnt_q;
      rcnt_d     = rcnt_q;
      rd_valid_d = rd_acc;
      if (wr_acc) begin
         wcnt_d = wcnt_q + 6'd1;
         if (wr_last) begin
            st_d[wbank_q] = FULL;
            wbank_d       = ~wbank_q;
         end else begin
            st_d[wbank_q] = FILLING;
         end
      end
      if (rd_acc) begin
         rcnt_d = rcnt_q + 6'd1;
         rsel_d = rbank_q;
         if (rd_last) begin
            st_d[rbank_q] = EMPTY;
            rbank_d       = ~rbank_q;
         end else begin
            st_d[rbank_q] = DRAINING;
         end
      end
   end

   always_comb begin
      ram0_cs  = 1'b0;
      ram0_rnw = 1'b1;
      ram0_add = 6'd0;
      ram1_cs  = 1'b0;
      ram1_rnw = 1'b1;
      ram1_add = 6'd0;
      if (rd_acc) begin
         if (rbank_q) begin
            ram1_cs  = 1'b1;
            ram1_add = raddr;
         end else begin
            ram0_cs  = 1'b1;
            ram0_add = raddr;
         end
      end
      if (wr_acc) begin
         if (wbank_q) begin
            ram1_cs  = 1'b1;
            ram1_rnw = 1'b0;
            ram1_add = wcnt_q;
         end else begin
            ram0_cs  = 1'b1;
            ram0_rnw = 1'b0;
            ram0_add = wcnt_q;
         end
      end
   end

endmodule

// File: tb/tb_dct_gram_pingpong.sv
// Bench for dct_gram_pingpong: vector table, directed block sequences and a randomized
// run against a block-queue reference model.
module tb_dct_gram_pingpong;
   localparam int DW = 24;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // instance A: transposed reader
   logic          wr_req = 1'b0, rd_req = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic          wr_rdy, rd_rdy, rd_valid, blk_done, wr_err;
   logic [DW-1:0] rd_data, ram_wr_data, ram0_q, ram1_q;
   logic          ram0_cs, ram1_cs, ram0_rnw, ram1_rnw;
   logic [5:0]    ram0_add, ram1_add;
   logic [DW-1:0] mem0 [64];
   logic [DW-1:0] mem1 [64];

   // instance B: linear reader
   logic          b_wr_req = 1'b0, b_rd_req = 1'b0;
   logic [DW-1:0] b_wr_data = '0;
   logic          b_wr_rdy, b_rd_rdy, b_rd_valid, b_blk_done, b_wr_err;
   logic [DW-1:0] b_rd_data, b_ram_wr_data, b_ram0_q, b_ram1_q;
   logic          b_ram0_cs, b_ram1_cs, b_ram0_rnw, b_ram1_rnw;
   logic [5:0]    b_ram0_add, b_ram1_add;
   logic [DW-1:0] b_mem0 [64];
   logic [DW-1:0] b_mem1 [64];

   dct_gram_pingpong #(.TRANSPOSE(1), .DW(DW)) dut_a (
      .clk_in(clk), .rst(rst), .wr_req(wr_req), .wr_data(wr_data), .wr_rdy(wr_rdy),
      .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_data(rd_data), .rd_valid(rd_valid),
      .blk_done(blk_done), .wr_err(wr_err), .ram0_cs(ram0_cs), .ram1_cs(ram1_cs),
      .ram0_rnw(ram0_rnw), .ram1_rnw(ram1_rnw), .ram0_add(ram0_add), .ram1_add(ram1_add),
      .ram_wr_data(ram_wr_data), .ram0_rd_data(ram0_q), .ram1_rd_data(ram1_q));

   dct_gram_pingpong #(.TRANSPOSE(0), .DW(DW)) dut_b (
      .clk_in(clk), .rst(rst), .wr_req(b_wr_req), .wr_data(b_wr_data), .wr_rdy(b_wr_rdy),
      .rd_req(b_rd_req), .rd_rdy(b_rd_rdy), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
      .blk_done(b_blk_done), .wr_err(b_wr_err), .ram0_cs(b_ram0_cs), .ram1_cs(b_ram1_cs),
      .ram0_rnw(b_ram0_rnw), .ram1_rnw(b_ram1_rnw), .ram0_add(b_ram0_add), .ram1_add(b_ram1_add),
      .ram_wr_data(b_ram_wr_data), .ram0_rd_data(b_ram0_q), .ram1_rd_data(b_ram1_q));

   // Synchronous RAMs with one-cycle registered read
   always @(posedge clk) begin
      if (ram0_cs) begin
         if (!ram0_rnw) mem0[ram0_add] <= ram_wr_data;
         else           ram0_q <= mem0[ram0_add];
      end
      if (ram1_cs) begin
         if (!ram1_rnw) mem1[ram1_add] <= ram_wr_data;
         else           ram1_q <= mem1[ram1_add];
      end
      if (b_ram0_cs) begin
         if (!b_ram0_rnw) b_mem0[b_ram0_add] <= b_ram_wr_data;
         else             b_ram0_q <= b_mem0[b_ram0_add];
      end
      if (b_ram1_cs) begin
         if (!b_ram1_rnw) b_mem1[b_ram1_add] <= b_ram_wr_data;
         else             b_ram1_q <= b_mem1[b_ram1_add];
      end
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Reference model: completed blocks in write order, plus the block being filled
   logic [DW-1:0] stored[$];
   logic [DW-1:0] partial[$];
   int rd_idx, wblk, rblk;
   logic [DW-1:0] last_rd;
   logic last_bd, last_err, last_wa, last_ra, last_both;

   function automatic int tr(input int k);
      return (k % 8) * 8 + k / 8;
   endfunction

   task automatic model_reset();
      stored.delete();
      partial.delete();
      rd_idx = 0;
      wblk   = 0;
      rblk   = 0;
   endtask

   task automatic cycle(input logic wq, input logic [DW-1:0] wd, input logic rq);
      logic ewr, erd, wa, ra;
      logic e_cs [2];
      logic e_rnw [2];
      logic [5:0] e_add [2];
      logic [DW-1:0] exp_d;
      exp_d = '0;
      @(negedge clk);
      wr_req = wq; wr_data = wd; rd_req = rq;
      #1;
      ewr = (stored.size() < 128);
      erd = (stored.size() >= 64);
      wa  = wq & ewr;
      ra  = rq & erd;
      e_cs[0] = 1'b0; e_cs[1] = 1'b0;
      e_rnw[0] = 1'b1; e_rnw[1] = 1'b1;
      e_add[0] = 6'd0; e_add[1] = 6'd0;
      if (ra) begin
         e_cs[rblk % 2]  = 1'b1;
         e_add[rblk % 2] = 6'(tr(rd_idx));
      end
      if (wa) begin
         e_cs[wblk % 2]  = 1'b1;
         e_rnw[wblk % 2] = 1'b0;
         e_add[wblk % 2] = 6'(partial.size());
      end
      chk("wr_rdy", 32'(wr_rdy), 32'(ewr));
      chk("rd_rdy", 32'(rd_rdy), 32'(erd));
      chk("wr_err", 32'(wr_err), 32'(wq & !ewr));
      chk("blk_done", 32'(blk_done), 32'(ra && rd_idx == 63));
      chk("ram0_cs", 32'(ram0_cs), 32'(e_cs[0]));
      chk("ram1_cs", 32'(ram1_cs), 32'(e_cs[1]));
      chk("ram0_rnw", 32'(ram0_rnw), 32'(e_rnw[0]));
      chk("ram1_rnw", 32'(ram1_rnw), 32'(e_rnw[1]));
      chk("ram0_add", 32'(ram0_add), 32'(e_add[0]));
      chk("ram1_add", 32'(ram1_add), 32'(e_add[1]));
      chk("ram_wr_data", 32'(ram_wr_data), 32'(wd));
      last_bd = blk_done; last_err = wr_err; last_wa = wa; last_ra = ra;
      last_both = ram0_cs & ram1_cs;
      if (ra) begin
         exp_d = stored[tr(rd_idx)];
         if (rd_idx == 63) begin
            repeat (64) void'(stored.pop_front());
            rd_idx = 0;
            rblk++;
         end else begin
            rd_idx++;
         end
      end
      if (wa) begin
         partial.push_back(wd);
         if (partial.size() == 64) begin
            foreach (partial[i]) stored.push_back(partial[i]);
            partial.delete();
            wblk++;
         end
      end
      @(posedge clk);
      #1;
      chk("rd_valid", 32'(rd_valid), 32'(ra));
      if (ra) chk("rd_data", 32'(rd_data), 32'(exp_d));
      last_rd = rd_data;
   endtask

   typedef struct {
      logic wq; logic rq; logic [DW-1:0] wd;
      logic e_wr_rdy; logic e_rd_rdy; logic e_cs0; logic e_rnw0; logic [5:0] e_add0; logic e_cs1;
   } vec_t;
   vec_t vt [5];

   int stall, both, wp;
   int wprob [6] = '{90, 50, 20, 70, 100, 35};

   initial begin
      vt[0] = '{1'b0, 1'b0, DW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
      vt[1] = '{1'b0, 1'b1, DW'(0), 1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0};
      vt[2] = '{1'b1, 1'b0, DW'(0), 1'b1, 1'b0, 1'b1, 1'b0, 6'd0, 1'b0};
      vt[3] = '{1'b1, 1'b0, DW'(1), 1'b1, 1'b0, 1'b1, 1'b0, 6'd1, 1'b0};
      vt[4] = '{1'b1, 1'b1, DW'(2), 1'b1, 1'b0, 1'b1, 1'b0, 6'd2, 1'b0};
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;

      foreach (vt[i]) begin
         @(negedge clk);
         wr_req = vt[i].wq; rd_req = vt[i].rq; wr_data = vt[i].wd;
         #1;
         chk($sformatf("vec%0d_wr_rdy", i), 32'(wr_rdy), 32'(vt[i].e_wr_rdy));
         chk($sformatf("vec%0d_rd_rdy", i), 32'(rd_rdy), 32'(vt[i].e_rd_rdy));
         chk($sformatf("vec%0d_cs0", i), 32'(ram0_cs), 32'(vt[i].e_cs0));
         chk($sformatf("vec%0d_rnw0", i), 32'(ram0_rnw), 32'(vt[i].e_rnw0));
         chk($sformatf("vec%0d_add0", i), 32'(ram0_add), 32'(vt[i].e_add0));
         chk($sformatf("vec%0d_cs1", i), 32'(ram1_cs), 32'(vt[i].e_cs1));
      end

      // Asynchronous reset in the middle of a fill
      @(negedge clk);
      wr_req = 1'b0; rd_req = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("rst_wr_rdy", 32'(wr_rdy), 32'd1);
      chk("rst_rd_rdy", 32'(rd_rdy), 32'd0);
      chk("rst_rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_cs0", 32'(ram0_cs), 32'd0);
      chk("rst_cs1", 32'(ram1_cs), 32'd0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      model_reset();

      // Single transposed block
      for (int i = 0; i < 64; i++) cycle(1'b1, DW'(i), 1'b0);
      for (int k = 0; k < 64; k++) begin
         cycle(1'b0, DW'(0), 1'b1);
         chk("xpose_seq", 32'(last_rd), 32'((k % 8) * 8 + k / 8));
         chk("xpose_blk_done", 32'(last_bd), 32'(k == 63));
      end

      // Ping-pong overlap: three blocks streaming
      stall = 0; both = 0;
      for (int i = 0; i < 256; i++) begin
         cycle(i < 192, DW'($urandom), i >= 64);
         if ((i < 192 && !last_wa) || (i >= 64 && !last_ra)) stall++;
         if (last_both) both++;
      end
      chk("overlap_stalls", 32'(stall), 32'd0);
      chk("overlap_dual_cs_cycles", 32'(both), 32'd128);

      // Backpressure, then the drain/refill edge
      for (int i = 0; i < 128; i++) cycle(1'b1, DW'(i), 1'b0);
      chk("bp_wr_rdy_low", 32'(wr_rdy), 32'd0);
      cycle(1'b1, DW'(24'h55555), 1'b0);
      chk("bp_wr_err", 32'(last_err), 32'd1);
      for (int k = 0; k < 64; k++) cycle(1'b0, DW'(0), 1'b1);
      chk("refill_old_word", 32'(last_rd), 32'd63);
      chk("bp_wr_rdy_back", 32'(wr_rdy), 32'd1);
      cycle(1'b1, DW'(24'hABCDE), 1'b0);
      for (int k = 0; k < 64; k++) cycle(1'b0, DW'(0), 1'b1);

      // Randomized traffic
      for (int s = 0; s < 6; s++) begin
         wp = wprob[s];
         for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 99) < wp, DW'($urandom), $urandom_range(0, 99) < 100 - wp / 2);
      end
      @(negedge clk);
      wr_req = 1'b0; rd_req = 1'b0;

      // Linear reader
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         b_wr_req = 1'b1; b_wr_data = DW'(i + 100);
      end
      @(negedge clk);
      b_wr_req = 1'b0;
      #1;
      chk("lin_rd_rdy", 32'(b_rd_rdy), 32'd1);
      for (int k = 0; k < 64; k++) begin
         @(negedge clk);
         b_rd_req = 1'b1;
         @(posedge clk);
         #1;
         chk("lin_rd_valid", 32'(b_rd_valid), 32'd1);
         chk("lin_rd_data", 32'(b_rd_data), 32'(k + 100));
      end
      @(negedge clk);
      b_rd_req = 1'b0;
      #1;
      chk("lin_rd_rdy_done", 32'(b_rd_rdy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
